// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, map cell constants, FSM states and helpers shared by the snake movement engine
package snake_pkg;
  typedef enum logic [1:0] {DIR_RIGHT = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_UP = 2'b11} dir_t;
  localparam logic [3:0] CELL_EMPTY = 4'b0000;
  localparam logic [3:0] CELL_OBSTACLE = 4'b0001;
  localparam logic [3:0] CELL_FRUIT = 4'b0010;
  localparam int SNAKE_BIT = 3;
  typedef enum logic [3:0] {
    IDLE, INIT, RUN, RD_HEAD, EVAL, WR_OLD, WR_NEW, RD_TAIL, CLR_TAIL, DEAD
  } state_t;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction
  function automatic logic [3:0] body_cell(input logic id, input dir_t d);
    return {1'b1, id, d};
  endfunction
endpackage

// File: rtl/snake_step.sv
// snake_step: one grid step from (x,y) in direction dir with toroidal wrap
module snake_step
  import snake_pkg::*;
#(
  parameter int MAPA_WIDTH = 40,
  parameter int MAPA_HEIGHT = 30
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  dir_t       dir,
  output logic [9:0] nx,
  output logic [9:0] ny
);
  assign nx = dir == DIR_RIGHT ? (x == 10'(MAPA_WIDTH - 1) ? 10'd0 : x + 10'd1) :
              dir == DIR_LEFT ? (x == 10'd0 ? 10'(MAPA_WIDTH - 1) : x - 10'd1) : x;
  assign ny = dir == DIR_DOWN ? (y == 10'(MAPA_HEIGHT - 1) ? 10'd0 : y + 10'd1) :
              dir == DIR_UP ? (y == 10'd0 ? 10'(MAPA_HEIGHT - 1) : y - 10'd1) : y;
endmodule

// File: rtl/snake_mover.sv
// snake_mover: per-snake movement engine driving the map state port (init body, step, grow, die)
module snake_mover
  import snake_pkg::*;
#(
  parameter int MAPA_WIDTH = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int SNAKE_ID = 0,
  parameter int INIT_X = 5,
  parameter int INIT_Y = 5,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] dir_in,
  output logic       state_read,
  output logic [9:0] state_xr,
  output logic [9:0] state_yr,
  input  logic [3:0] state_rdata,
  output logic       state_write,
  output logic [9:0] state_xw,
  output logic [9:0] state_yw,
  output logic [3:0] state_wdata,
  output logic       busy,
  output logic       dead,
  output logic       fruit_eaten,
  output logic [9:0] length,
  output logic [9:0] head_x,
  output logic [9:0] head_y
);
  localparam logic id = 1'(SNAKE_ID);
  localparam logic [9:0] init_x = 10'(INIT_X);
  localparam logic [9:0] init_y = 10'(INIT_Y);
  state_t state_q, state_d;
  dir_t dir_q, dir_d, req_dir;
  logic [3:0] cnt_q, cnt_d, wd_q, wd_d;
  logic [9:0] hx_q, hx_d, hy_q, hy_d, tx_q, tx_d, ty_q, ty_d, nx_q, nx_d, ny_q, ny_d;
  logic [9:0] len_q, len_d, xr_q, xr_d, yr_q, yr_d, xw_q, xw_d, yw_q, yw_d;
  logic [9:0] step_hx, step_hy, step_tx, step_ty;
  logic fruit_q, fruit_d, fe_q, fe_d, dead_q, dead_d, rd_q, rd_d, wr_q, wr_d;
  assign req_dir = dir_t'(dir_in) == opposite(dir_q) ? dir_q : dir_t'(dir_in);
  snake_step #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT)) u_head (
    .x(hx_q), .y(hy_q), .dir(req_dir), .nx(step_hx), .ny(step_hy)
  );
  snake_step #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT)) u_tail (
    .x(tx_q), .y(ty_q), .dir(dir_t'(state_rdata[1:0])), .nx(step_tx), .ny(step_ty)
  );
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    hx_d = hx_q;
    hy_d = hy_q;
    tx_d = tx_q;
    ty_d = ty_q;
    nx_d = nx_q;
    ny_d = ny_q;
    len_d = len_q;
    fruit_d = fruit_q;
    dead_d = dead_q;
    fe_d = 1'b0;
    rd_d = 1'b0;
    xr_d = '0;
    yr_d = '0;
    wr_d = 1'b0;
    xw_d = '0;
    yw_d = '0;
    wd_d = '0;
    case (state_q)
      IDLE, DEAD: if (start) begin
        state_d = INIT;
        cnt_d = '0;
        wr_d = 1'b1;
        xw_d = init_x;
        yw_d = init_y;
        wd_d = body_cell(id, DIR_RIGHT);
      end
      INIT: if (cnt_q == 4'(INIT_LEN - 1)) begin
        state_d = RUN;
        tx_d = init_x;
        ty_d = init_y;
        hx_d = init_x + 10'(INIT_LEN - 1);
        hy_d = init_y;
        len_d = 10'(INIT_LEN);
        dir_d = DIR_RIGHT;
        dead_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 4'd1;
        wr_d = 1'b1;
        xw_d = init_x + 10'(cnt_q) + 10'd1;
        yw_d = init_y;
        wd_d = body_cell(id, DIR_RIGHT);
      end
      RUN: if (tick) begin
        state_d = RD_HEAD;
        dir_d = req_dir;
        nx_d = step_hx;
        ny_d = step_hy;
        rd_d = 1'b1;
        xr_d = step_hx;
        yr_d = step_hy;
      end
      RD_HEAD: state_d = EVAL;
      EVAL: if (state_rdata[SNAKE_BIT] || state_rdata == CELL_OBSTACLE) begin
        state_d = DEAD;
        dead_d = 1'b1;
      end else begin
        state_d = WR_OLD;
        fruit_d = state_rdata == CELL_FRUIT;
        wr_d = 1'b1;
        xw_d = hx_q;
        yw_d = hy_q;
        wd_d = body_cell(id, dir_q);
      end
      WR_OLD: begin
        state_d = WR_NEW;
        wr_d = 1'b1;
        xw_d = nx_q;
        yw_d = ny_q;
        wd_d = body_cell(id, dir_q);
        hx_d = nx_q;
        hy_d = ny_q;
        fe_d = fruit_q;
        len_d = fruit_q && len_q != 10'd1023 ? len_q + 10'd1 : len_q;
      end
      WR_NEW: if (fruit_q) state_d = RUN;
      else begin
        state_d = RD_TAIL;
        rd_d = 1'b1;
        xr_d = tx_q;
        yr_d = ty_q;
      end
      RD_TAIL: begin
        state_d = CLR_TAIL;
        wr_d = 1'b1;
        xw_d = tx_q;
        yw_d = ty_q;
        wd_d = CELL_EMPTY;
      end
      CLR_TAIL: begin
        state_d = RUN;
        tx_d = step_tx;
        ty_d = step_ty;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q <= DIR_RIGHT;
      cnt_q <= '0;
      hx_q <= '0;
      hy_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      nx_q <= '0;
      ny_q <= '0;
      len_q <= '0;
      fruit_q <= 1'b0;
      dead_q <= 1'b0;
      fe_q <= 1'b0;
      rd_q <= 1'b0;
      xr_q <= '0;
      yr_q <= '0;
      wr_q <= 1'b0;
      xw_q <= '0;
      yw_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      hx_q <= hx_d;
      hy_q <= hy_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      len_q <= len_d;
      fruit_q <= fruit_d;
      dead_q <= dead_d;
      fe_q <= fe_d;
      rd_q <= rd_d;
      xr_q <= xr_d;
      yr_q <= yr_d;
      wr_q <= wr_d;
      xw_q <= xw_d;
      yw_q <= yw_d;
      wd_q <= wd_d;
    end
  end
  assign busy = !(state_q == IDLE || state_q == RUN || state_q == DEAD);
  assign dead = dead_q;
  assign fruit_eaten = fe_q;
  assign length = len_q;
  assign head_x = hx_q;
  assign head_y = hy_q;
  assign state_read = rd_q;
  assign state_xr = xr_q;
  assign state_yr = yr_q;
  assign state_write = wr_q;
  assign state_xw = xw_q;
  assign state_yw = yw_q;
  assign state_wdata = wd_q;
endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: scoreboard bench with a map model checking every map-port transaction of snake_mover
module tb_snake_mover;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tick = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic state_read, state_write, busy, dead, fruit_eaten;
  logic [9:0] state_xr, state_yr, state_xw, state_yw, length, head_x, head_y;
  logic [3:0] state_rdata = 4'd0, state_wdata;
  int n_checks = 0, n_errors = 0;
  logic [3:0] map [40][30];
  logic [25:0] exp_q[$];
  logic [19:0] body[$];
  logic [1:0] m_dir = 2'd0;
  always #5 clk = ~clk;
  snake_mover dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .dir_in(dir_in),
    .state_read(state_read), .state_xr(state_xr), .state_yr(state_yr), .state_rdata(state_rdata),
    .state_write(state_write), .state_xw(state_xw), .state_yw(state_yw), .state_wdata(state_wdata),
    .busy(busy), .dead(dead), .fruit_eaten(fruit_eaten), .length(length),
    .head_x(head_x), .head_y(head_y)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [25:0] got;
    if (state_read && state_xr < 10'd40 && state_yr < 10'd30)
      state_rdata = map[int'(state_xr)][int'(state_yr)];
    if (state_read || state_write) begin
      got = {state_read, state_write, state_read ? state_xr : state_xw,
             state_read ? state_yr : state_yw, state_write ? state_wdata : 4'h0};
      if (exp_q.size() == 0) check("extra_txn", 32'(got), 32'h0);
      else check("txn", 32'(got), 32'(exp_q.pop_front()));
    end
    if (state_write && state_xw < 10'd40 && state_yw < 10'd30)
      map[int'(state_xw)][int'(state_yw)] = state_wdata;
  end
  task automatic do_start();
    int n;
    body.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b01, 10'(5 + i), 10'd5, 4'b1000});
      body.push_back({10'(5 + i), 10'd5});
    end
    m_dir = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("init_busy", n, 3);
    check("init_dead", dead, 0);
    check("init_len", length, 3);
    check("init_hx", head_x, 7);
    check("init_hy", head_y, 5);
  endtask
  task automatic do_tick(input logic [1:0] d, input bit extra);
    logic [1:0] nd;
    logic [9:0] hx, hy, nx, ny, tx, ty;
    logic [3:0] c;
    int exp_busy, n, fe_n, fe_at;
    bit die;
    nd = (d == (m_dir ^ 2'b10)) ? m_dir : d;
    {hx, hy} = body[$];
    nx = nd == 2'd0 ? (hx == 10'd39 ? 10'd0 : hx + 10'd1) : nd == 2'd2 ? (hx == 10'd0 ? 10'd39 : hx - 10'd1) : hx;
    ny = nd == 2'd1 ? (hy == 10'd29 ? 10'd0 : hy + 10'd1) : nd == 2'd3 ? (hy == 10'd0 ? 10'd29 : hy - 10'd1) : hy;
    c = map[int'(nx)][int'(ny)];
    exp_q.push_back({2'b10, nx, ny, 4'h0});
    die = c[3] || c == 4'h1;
    if (die) exp_busy = 2;
    else begin
      m_dir = nd;
      exp_q.push_back({2'b01, hx, hy, 2'b10, nd});
      exp_q.push_back({2'b01, nx, ny, 2'b10, nd});
      body.push_back({nx, ny});
      if (c == 4'h2) exp_busy = 4;
      else begin
        {tx, ty} = body.pop_front();
        exp_q.push_back({2'b10, tx, ty, 4'h0});
        exp_q.push_back({2'b01, tx, ty, 4'h0});
        exp_busy = 6;
      end
    end
    dir_in = d;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    n = 0;
    fe_n = 0;
    fe_at = 0;
    while (busy && n < 20) begin
      n++;
      if (fruit_eaten) begin
        fe_n++;
        fe_at = n;
      end
      tick = extra && n == 1;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    check("busy_cycles", n, exp_busy);
    check("fruit_pulses", fe_n, (c == 4'h2 && !die) ? 1 : 0);
    if (c == 4'h2 && !die) check("fruit_cycle", fe_at, 4);
    check("dead", dead, die);
    check("length", length, body.size());
    if (!die) begin
      check("head_x", head_x, body[$][19:10]);
      check("head_y", head_y, body[$][9:0]);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bit seen;
    for (int x = 0; x < 40; x++) for (int y = 0; y < 30; y++) map[x][y] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_dead", dead, 0);
    check("rst_len", length, 0);
    check("rst_head", {head_x, head_y}, 0);
    check("rst_strobes", {state_read, state_write, fruit_eaten}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    do_tick(2'd0, 1'b0);
    check("tail_step_len", length, 3);
    for (int i = 0; i < 31; i++) do_tick(2'd0, 1'b0);
    check("edge_x", head_x, 39);
    do_tick(2'd0, 1'b0);
    check("wrap_x", head_x, 0);
    for (int i = 0; i < 5; i++) do_tick(2'd3, 1'b0);
    check("edge_y", head_y, 0);
    do_tick(2'd3, 1'b0);
    check("wrap_y", head_y, 29);
    do_tick(2'd0, 1'b0);
    do_tick(2'd2, 1'b1);
    check("reverse_x", head_x, 2);
    check("reverse_y", head_y, 29);
    map[3][29] = 4'h2;
    do_tick(2'd0, 1'b0);
    check("fruit_len", length, 4);
    map[4][29] = 4'h1;
    do_tick(2'd0, 1'b0);
    check("dead_flag", dead, 1);
    dir_in = 2'd1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      seen |= busy;
      @(posedge clk); #1;
    end
    check("dead_tick_busy", seen, 0);
    check("dead_hold", dead, 1);
    do_start();
    do_tick(2'd1, 1'b0);
    check("restart_y", head_y, 6);
    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
